mem_responder: RTL

- Memory-side responder for the cache's miss/write-through traffic: a 256-word, 32-bit main memory behind a valid/ready request channel with a fixed access latency.
- Read requests return data on a separate response handshake.
- Writes are posted into a small FIFO write buffer and drained into the array in the background.
- Sits between the cache controller and the storage array; the debug port reads the array for the chk display.

---
 rtl/mem_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: 256 x 32-bit main memory behind a valid/ready request channel.
// Reads return data after a fixed latency on a separate response handshake;
// writes are posted into a FIFO write buffer and drained in the background.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (req_ready is combinational)
//   req_we          1 = write, 0 = read
//   req_addr        word address
//   req_wdata       write data
//   resp_valid/ready read-response handshake
//   resp_rdata      read data, stable while resp_valid
//   dbg_addr        debug read address
//   dbg_data        combinational array contents at dbg_addr (buffer not consulted)
//   wb_count        write-buffer occupancy
//   busy            FSM not idle or buffer non-empty
module mem_responder #(
   parameter  int unsigned LATENCY  = 4,
   parameter  int unsigned WB_DEPTH = 4,
   localparam int unsigned AW       = 8,
   localparam int unsigned DW       = 32,
   localparam int unsigned CW       = 4,
   localparam int unsigned MEM_DEPTH = 256,
   localparam int unsigned PTR_W    = $clog2(WB_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_rdata,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic [CW-1:0] wb_count,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RESP     = 2'd2,
      WR_DRAIN = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [CW-1:0] WB_FULL  = CW'(WB_DEPTH);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   snap_q, snap_d;
   logic            resp_valid_q, resp_valid_d;
   logic [DW-1:0]   resp_rdata_q, resp_rdata_d;

   logic [DW-1:0]   mem_q [MEM_DEPTH];
   logic [AW-1:0]   wb_addr_q [WB_DEPTH];
   logic [DW-1:0]   wb_data_q [WB_DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CW-1:0]   count_q, count_d;

   logic            not_full;
   logic            push;
   logic            pop;
   logic            rd_acc;
   logic [DW-1:0]   fwd_data;

   // Acceptance: writes only need buffer space; reads also need an idle FSM.
   // A full buffer refuses reads too, so the pending drain always runs first.
   always_comb begin
      not_full  = (count_q < WB_FULL);
      req_ready = not_full && (req_we || (state_q == IDLE));
      push      = req_valid && req_we && req_ready;
      rd_acc    = req_valid && !req_we && req_ready;
   end

   // Read snapshot: scan oldest to newest so the newest matching entry wins.
   always_comb begin
      fwd_data = mem_q[req_addr];
      for (int i = 0; i < int'(WB_DEPTH); i++) begin
         if ((CW'(i) < count_q) && (wb_addr_q[head_q + PTR_W'(i)] == req_addr)) begin
            fwd_data = wb_data_q[head_q + PTR_W'(i)];
         end
      end
   end

   // FSM next state, latency counter and response register updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      snap_d       = snap_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_acc) begin
               state_d = RD_WAIT;
               cnt_d   = CNT_INIT;
               snap_d  = fwd_data;
            end else if (count_q != '0) begin
               state_d = WR_DRAIN;
               cnt_d   = CNT_INIT;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = snap_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            resp_valid_d = 1'b1;
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         WR_DRAIN: begin
            if (cnt_q == '0) begin
               pop     = (count_q != '0);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Occupancy: a push and pop on the same edge leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // FSM and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         snap_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         snap_q       <= snap_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Write buffer storage and pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(WB_DEPTH); i++) begin
            wb_addr_q[i] <= '0;
            wb_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            wb_addr_q[tail_q] <= req_addr;
            wb_data_q[tail_q] <= req_wdata;
            tail_q            <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage array; only the drain of the head entry writes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (pop) begin
         mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign dbg_data   = mem_q[dbg_addr];
   assign wb_count   = count_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule
